updn_cntr: RTL and testbench
============================

UPDN_CNTR -- requirements
Module: updn_cntr

Interface
REQ-001 The block SHALL have parameter COUNT_WIDTH, default 8, giving the counter width in bits (legal range 2..32).
REQ-002 The block SHALL have parameter PRE_WIDTH, default 4, giving the prescaler width in bits (legal range 1..16).
REQ-003 The block SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-005 The block SHALL have port en, input, 1 bit: count enable; gates the prescaler.
REQ-006 The block SHALL have port up_dn, input, 1 bit: direction, 1 = up, 0 = down.
REQ-007 The block SHALL have port sat_mode, input, 1 bit: 1 = saturate at bounds, 0 = wrap.
REQ-008 The block SHALL have port clr, input, 1 bit: synchronous clear.
REQ-009 The block SHALL have port load, input, 1 bit: synchronous load strobe.
REQ-010 The block SHALL have port load_val, input, COUNT_WIDTH bits: value for load.
REQ-011 The block SHALL have port max_val, input, COUNT_WIDTH bits: runtime upper bound (modulus - 1).
REQ-012 The block SHALL have port prescale, input, PRE_WIDTH bits: step every prescale+1 enabled cycles.
REQ-013 The block SHALL have port ovf_clr, input, 1 bit: clears the sticky overflow flag.
REQ-014 The block SHALL have port count, output, COUNT_WIDTH bits: registered counter value.
REQ-015 The block SHALL have port tc, output, 1 bit: registered one-cycle terminal-count pulse.
REQ-016 The block SHALL have port ovf, output, 1 bit: sticky boundary-event flag.

Function
REQ-017 The block SHALL keep an internal prescaler pre_cnt; on each cycle with en=1, a tick fires if pre_cnt == prescale, then pre_cnt returns to 0; otherwise pre_cnt increments; with en=0, pre_cnt holds.
REQ-018 The block SHALL apply per-cycle priority clr > load > tick step > hold.
REQ-019 The block SHALL, on clr, set count=0 and pre_cnt=0, with no tc and no ovf set.
REQ-020 The block SHALL, on load, set count=min(load_val, max_val) and pre_cnt=0, with no tc and no ovf set.
REQ-021 The block SHALL, on an up tick with count < max_val, set count = count+1.
REQ-022 The block SHALL, on an up tick with count >= max_val, set count=0 (wrap) or count=max_val (sat).
REQ-023 The block SHALL, on a down tick with 0 < count <= max_val, set count = count-1.
REQ-024 The block SHALL, on a down tick with count=0, set count=max_val (wrap) or hold 0 (sat).
REQ-025 The block SHALL, on a down tick with count > max_val (max_val lowered at runtime), set count=max_val; this is not a boundary event.
REQ-026 The block SHALL define a boundary event as a tick taking the REQ-022 or REQ-024 path, in either mode.
REQ-027 The block SHALL assert tc for exactly the one cycle following a boundary event (registered; latency 1).
REQ-028 The block SHALL set ovf on a boundary event and clear it on ovf_clr; set SHALL win when both occur in the same cycle.
REQ-029 The block SHALL handle max_val=0 as follows: each up or down tick is a boundary event and count stays 0.
REQ-030 The block SHALL apply a prescale change from the next cycle, compared against the current pre_cnt; if pre_cnt > prescale, pre_cnt SHALL keep incrementing and wrap naturally through its full width.
REQ-031 The block SHALL contain no combinational path from any input to count, tc or ovf.

Reset
REQ-032 The block SHALL, while rst_n=0, force count=0, pre_cnt=0, tc=0 and ovf=0 asynchronously, regardless of clk.
REQ-033 The block SHALL accept its first step on the first rising edge after rst_n deasserts; reset asserted mid-count SHALL discard the prescaler phase.

Verification
REQ-034 The bench SHALL cover: COUNT_WIDTH=8, max_val=9, prescale=0, up, wrap, en=1 for 12 cycles -> count 1..9,0,1,2; tc high exactly one cycle after 9->0; ovf=1.
REQ-035 The bench SHALL cover: prescale=3, up, en=1 from count=0 -> count increments on every 4th enabled cycle; en=0 for 2 cycles mid-period delays the step by 2 cycles.
REQ-036 The bench SHALL cover: down, sat_mode=1, load 2 with max_val=5 -> 1, 0, 0, 0; tc pulses after each tick at 0; ovf stays set until ovf_clr, and ovf_clr coincident with a boundary tick leaves ovf=1.
REQ-037 The bench SHALL cover: load=1 and clr=1 together with load_val=7 -> count=0; load_val=200 with max_val=50 -> count=50.
REQ-038 The bench SHALL cover: count=40, max_val changed to 20; up tick -> 0 (wrap) or 20 (sat) with tc; down tick -> 20 with no tc.
REQ-039 The bench SHALL cover: rst_n pulsed low between clock edges at count=33 -> count, tc, ovf read 0 immediately, not waiting for the next clk edge.

Source files
------------

// File: rtl/updn_cntr.sv
// rtl/updn_cntr.sv - prescaled up/down counter with runtime modulus, wrap/saturate modes, tc pulse and sticky ovf
module updn_cntr #(
    parameter int COUNT_WIDTH = 8,
    parameter int PRE_WIDTH   = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en,
    input  logic                   up_dn,
    input  logic                   sat_mode,
    input  logic                   clr,
    input  logic                   load,
    input  logic [COUNT_WIDTH-1:0] load_val,
    input  logic [COUNT_WIDTH-1:0] max_val,
    input  logic [PRE_WIDTH-1:0]   prescale,
    input  logic                   ovf_clr,
    output logic [COUNT_WIDTH-1:0] count,
    output logic                   tc,
    output logic                   ovf
);

    logic [PRE_WIDTH-1:0]   pre_cnt;
    logic [PRE_WIDTH-1:0]   pre_next;
    logic [COUNT_WIDTH-1:0] count_next;
    logic [COUNT_WIDTH-1:0] load_clip;
    logic                   tick;
    logic                   boundary;

    // Equality (not >=) so a prescale lowered below pre_cnt lets pre_cnt run round its full width.
    assign tick      = en && (pre_cnt == prescale);
    assign load_clip = (load_val > max_val) ? max_val : load_val;

    always_comb begin
        pre_next   = pre_cnt;
        count_next = count;
        boundary   = 1'b0;
        if (clr) begin
            pre_next   = '0;
            count_next = '0;
        end else if (load) begin
            pre_next   = '0;
            count_next = load_clip;
        end else begin
            if (en) begin
                pre_next = tick ? '0 : pre_cnt + 1'b1;
            end
            if (tick) begin
                if (up_dn) begin
                    if (count < max_val) begin
                        count_next = count + 1'b1;
                    end else begin
                        boundary   = 1'b1;
                        count_next = sat_mode ? max_val : '0;
                    end
                end else begin
                    if (count == '0) begin
                        boundary   = 1'b1;
                        count_next = sat_mode ? '0 : max_val;
                    end else if (count > max_val) begin
                        // Bound was lowered under us: snap to it quietly.
                        count_next = max_val;
                    end else begin
                        count_next = count - 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_cnt <= '0;
            count   <= '0;
            tc      <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            pre_cnt <= pre_next;
            count   <= count_next;
            tc      <= boundary;
            if (boundary) begin
                ovf <= 1'b1;
            end else if (ovf_clr) begin
                ovf <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_updn_cntr.sv
// tb/tb_updn_cntr.sv - scoreboard bench for updn_cntr with directed vectors
module tb_updn_cntr;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       up_dn;
    logic       sat_mode;
    logic       clr;
    logic       load;
    logic [7:0] load_val;
    logic [7:0] max_val;
    logic [3:0] prescale;
    logic       ovf_clr;
    logic [7:0] count;
    logic       tc;
    logic       ovf;

    typedef struct packed {
        logic [7:0] c;
        logic       t;
        logic       o;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    updn_cntr #(.COUNT_WIDTH(8), .PRE_WIDTH(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .up_dn    (up_dn),
        .sat_mode (sat_mode),
        .clr      (clr),
        .load     (load),
        .load_val (load_val),
        .max_val  (max_val),
        .prescale (prescale),
        .ovf_clr  (ovf_clr),
        .count    (count),
        .tc       (tc),
        .ovf      (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    // Monitor: the counter presents a result every cycle; compare away from the rising edge.
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("count", count, e.c);
            check("tc", {7'd0, tc}, {7'd0, e.t});
            check("ovf", {7'd0, ovf}, {7'd0, e.o});
        end
    end

    task automatic cyc(input logic e, input logic ud, input logic sat, input logic c,
                       input logic ld, input logic [7:0] lv, input logic [7:0] mv,
                       input logic [3:0] ps, input logic oc,
                       input logic [7:0] ec, input logic et, input logic eo);
        exp_t x;
        @(negedge clk);
        rst_n    = 1'b1;
        en       = e;
        up_dn    = ud;
        sat_mode = sat;
        clr      = c;
        load     = ld;
        load_val = lv;
        max_val  = mv;
        prescale = ps;
        ovf_clr  = oc;
        @(posedge clk);
        #1;
        x.c = ec;
        x.t = et;
        x.o = eo;
        exp_q.push_back(x);
    endtask

    initial begin
        rst_n = 1'b1; en = 0; up_dn = 0; sat_mode = 0; clr = 0; load = 0;
        load_val = 0; max_val = 0; prescale = 0; ovf_clr = 0;
        #1 rst_n = 1'b0;
        #2;
        check("rst_count", count, 8'd0);
        check("rst_tc", {7'd0, tc}, 8'd0);
        check("rst_ovf", {7'd0, ovf}, 8'd0);

        // max 9, prescale 0, up, wrap
        for (int i = 1; i <= 12; i++) begin
            cyc(1, 1, 0, 0, 0, 0, 9, 0, 0, 8'(i % 10), (i == 10), (i >= 10));
        end
        cyc(0, 1, 0, 1, 0, 0, 9, 0, 1, 0, 0, 0);

        // prescale 3, with a 2-cycle enable gap mid-period
        cyc(1, 1, 0, 0, 0, 0, 9, 3, 0, 0, 0, 0);
        cyc(1, 1, 0, 0, 0, 0, 9, 3, 0, 0, 0, 0);
        cyc(1, 1, 0, 0, 0, 0, 9, 3, 0, 0, 0, 0);
        cyc(1, 1, 0, 0, 0, 0, 9, 3, 0, 1, 0, 0);
        cyc(1, 1, 0, 0, 0, 0, 9, 3, 0, 1, 0, 0);
        cyc(1, 1, 0, 0, 0, 0, 9, 3, 0, 1, 0, 0);
        cyc(1, 1, 0, 0, 0, 0, 9, 3, 0, 1, 0, 0);
        cyc(1, 1, 0, 0, 0, 0, 9, 3, 0, 2, 0, 0);
        cyc(1, 1, 0, 0, 0, 0, 9, 3, 0, 2, 0, 0);
        cyc(1, 1, 0, 0, 0, 0, 9, 3, 0, 2, 0, 0);
        cyc(0, 1, 0, 0, 0, 0, 9, 3, 0, 2, 0, 0);
        cyc(0, 1, 0, 0, 0, 0, 9, 3, 0, 2, 0, 0);
        cyc(1, 1, 0, 0, 0, 0, 9, 3, 0, 2, 0, 0);
        cyc(1, 1, 0, 0, 0, 0, 9, 3, 0, 3, 0, 0);

        // down, saturate, load 2 under max 5
        cyc(0, 0, 1, 0, 1, 2, 5, 0, 0, 2, 0, 0);
        cyc(1, 0, 1, 0, 0, 0, 5, 0, 0, 1, 0, 0);
        cyc(1, 0, 1, 0, 0, 0, 5, 0, 0, 0, 0, 0);
        cyc(1, 0, 1, 0, 0, 0, 5, 0, 0, 0, 1, 1);
        cyc(1, 0, 1, 0, 0, 0, 5, 0, 0, 0, 1, 1);
        cyc(0, 0, 1, 0, 0, 0, 5, 0, 0, 0, 0, 1);
        cyc(0, 0, 1, 0, 0, 0, 5, 0, 1, 0, 0, 0);
        cyc(1, 0, 1, 0, 0, 0, 5, 0, 1, 0, 1, 1);
        cyc(0, 0, 1, 0, 0, 0, 5, 0, 0, 0, 0, 1);

        // clr beats load; load clipped to max_val
        cyc(0, 1, 0, 1, 1, 7, 9, 0, 1, 0, 0, 0);
        cyc(0, 1, 0, 0, 1, 200, 50, 0, 0, 50, 0, 0);

        // max_val lowered below count
        cyc(0, 1, 0, 0, 1, 40, 50, 0, 0, 40, 0, 0);
        cyc(1, 1, 0, 0, 0, 0, 20, 0, 0, 0, 1, 1);
        cyc(0, 1, 0, 0, 1, 40, 50, 0, 1, 40, 0, 0);
        cyc(1, 1, 1, 0, 0, 0, 20, 0, 0, 20, 1, 1);
        cyc(0, 1, 0, 0, 1, 40, 50, 0, 1, 40, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 20, 0, 0, 20, 0, 0);

        // max_val 0: every tick is a boundary
        cyc(0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);

        // asynchronous reset between edges at count 33
        cyc(1, 1, 0, 0, 1, 33, 50, 0, 0, 33, 0, 1);
        @(negedge clk);
        en = 1'b0;
        load = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_count", count, 8'd0);
        check("async_rst_tc", {7'd0, tc}, 8'd0);
        check("async_rst_ovf", {7'd0, ovf}, 8'd0);

        // first rising edge after release steps
        cyc(1, 1, 0, 0, 0, 0, 50, 0, 0, 1, 0, 0);
        cyc(1, 1, 0, 0, 0, 0, 50, 0, 0, 2, 0, 0);

        repeat (3) @(negedge clk);
        #1;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL queue_drain: got %0d left expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
